// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {S_RUN, S_MDU, S_DWAIT} hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_flush: 1'b0
  };

  // A load to $0 never creates a dependency since $0 is hardwired.
  function automatic logic load_use_hit(input logic ex_mem_read, input logic [4:0] ex_rd,
                                        input logic use_rs, input logic [4:0] rs,
                                        input logic use_rt, input logic [4:0] rt);
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((use_rs && (rs == ex_rd)) || (use_rt && (rt == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - pipeline status inputs and register-control outputs of the hazard controller
interface hazard_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_mdu_start;
  logic       ex_redirect;
  logic       mem_valid;
  logic       mem_mem_read;
  logic       dmem_req;
  logic       dmem_ready;
  logic       wb_valid;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;
  logic       use_mem_back;
  logic       use_wb_back;
  logic       mdu_done;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd, ex_mdu_start,
           ex_redirect, mem_valid, mem_mem_read, dmem_req, dmem_ready, wb_valid,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush,
           memwb_flush, use_mem_back, use_wb_back, mdu_done
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd, ex_mdu_start,
           ex_redirect, mem_valid, mem_mem_read, dmem_req, dmem_ready, wb_valid,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush,
           memwb_flush, use_mem_back, use_wb_back, mdu_done
  );
endinterface

// File: rtl/hz_mdu_timer.sv
// rtl/hz_mdu_timer.sv - loadable down-counter timing the remaining MDU occupancy of EX
module hz_mdu_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  // Neither load nor dec means frozen, which is how a data-memory wait pauses the MDU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding-qualifier controller for the 5-stage core
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_if.slave          hz,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int CW = $clog2(MDU_CYCLES);

  hz_state_t  state, state_nx, eff;
  pipe_ctrl_t ctrl;
  logic       mdu_pend, mdu_pend_nx, mdu_done_nx;
  logic       dwait, lu_hit, tmr_load, tmr_dec, tmr_zero;

  hz_mdu_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CW'(MDU_CYCLES - 2)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    ctrl        = PIPE_RUN;
    state_nx    = state;
    mdu_pend_nx = mdu_pend;
    mdu_done_nx = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    dwait       = hz.dmem_req && !hz.dmem_ready;
    lu_hit      = load_use_hit(hz.ex_mem_read, hz.ex_rd, hz.id_use_rs, hz.id_rs,
                               hz.id_use_rt, hz.id_rt);
    // The cycle the memory answers already behaves like the state we paused in.
    eff = state;
    if (state == S_DWAIT && !dwait) eff = mdu_pend ? S_MDU : S_RUN;

    if (dwait) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_en    = 1'b0;
      ctrl.memwb_flush = 1'b1;
      state_nx         = S_DWAIT;
      if (state == S_MDU)      mdu_pend_nx = 1'b1;
      else if (state == S_RUN) mdu_pend_nx = 1'b0;
    end else begin
      mdu_pend_nx = 1'b0;
      case (eff)
        S_MDU: begin
          if (tmr_zero) begin
            state_nx    = S_RUN;
            mdu_done_nx = 1'b1;
          end else begin
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_en     = 1'b0;
            ctrl.exmem_flush = 1'b1;
            tmr_dec          = 1'b1;
            state_nx         = S_MDU;
          end
        end
        default: begin
          state_nx = S_RUN;
          if (hz.ex_mdu_start) begin
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_en     = 1'b0;
            ctrl.exmem_flush = 1'b1;
            tmr_load         = 1'b1;
            state_nx         = S_MDU;
          end else if (hz.ex_redirect) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (lu_hit) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RUN;
      mdu_pend     <= 1'b0;
      hz.mdu_done  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state       <= state_nx;
      mdu_pend    <= mdu_pend_nx;
      hz.mdu_done <= mdu_done_nx;
      if (!ctrl.pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign hz.pc_en        = ctrl.pc_en;
  assign hz.ifid_en      = ctrl.ifid_en;
  assign hz.idex_en      = ctrl.idex_en;
  assign hz.exmem_en     = ctrl.exmem_en;
  assign hz.ifid_flush   = ctrl.ifid_flush;
  assign hz.idex_flush   = ctrl.idex_flush;
  assign hz.exmem_flush  = ctrl.exmem_flush;
  assign hz.memwb_flush  = ctrl.memwb_flush;
  assign hz.use_mem_back = hz.mem_valid && !hz.mem_mem_read;
  assign hz.use_wb_back  = hz.wb_valid;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int MDU = 8;
  localparam int CW  = 4;
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush}
  localparam logic [7:0] C_RUN = 8'b1101_0100;
  localparam logic [7:0] C_MDU = 8'b0000_0110;
  localparam logic [7:0] C_DW  = 8'b0000_0001;
  localparam logic [7:0] C_LU  = 8'b0001_1100;
  localparam logic [7:0] C_RED = 8'b1111_1100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] stall_cycles;
  int            n_tests = 0;
  int            n_fail = 0;

  hazard_if hif ();

  hazard_ctrl #(.MDU_CYCLES(MDU), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (hif),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  wire [7:0] ctrl_obs = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
                         hif.idex_flush, hif.exmem_en, hif.exmem_flush, hif.memwb_flush};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
    hif.ex_mem_read = 1'b0; hif.ex_rd = 5'd0; hif.ex_mdu_start = 1'b0;
    hif.ex_redirect = 1'b0; hif.mem_valid = 1'b0; hif.mem_mem_read = 1'b0;
    hif.dmem_req = 1'b0; hif.dmem_ready = 1'b1; hif.wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0; hif.ex_mdu_start = 1'b1;
    tick();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RUN) begin n_fail++; $display("FAIL reset_ctrl got %b want %b", ctrl_obs, C_RUN); end
    n_tests++;
    if (hif.mdu_done !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_done got %b want 0", hif.mdu_done); end
    n_tests++;
    if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    do_reset();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd2; hif.id_rs = 5'd2; hif.id_use_rs = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_LU) begin n_fail++; $display("FAIL lu_rs got %b want %b", ctrl_obs, C_LU); end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RUN) begin n_fail++; $display("FAIL lu_release got %b want %b", ctrl_obs, C_RUN); end
    n_tests++;
    if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cycles); end
    tick();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd7; hif.id_rt = 5'd7; hif.id_use_rt = 1'b1;
    hif.id_rs = 5'd7; hif.id_use_rs = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_LU) begin n_fail++; $display("FAIL lu_rt got %b want %b", ctrl_obs, C_LU); end
    tick();
    hif.id_use_rt = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RUN) begin n_fail++; $display("FAIL lu_unused_src got %b want %b", ctrl_obs, C_RUN); end
    tick();
    hif.ex_rd = 5'd0; hif.id_rs = 5'd0; hif.id_use_rs = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RUN) begin n_fail++; $display("FAIL lu_r0 got %b want %b", ctrl_obs, C_RUN); end
  endtask

  task automatic test_forward_quals();
    logic [3:0] pat;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pat = 4'(i);
      hif.mem_valid = pat[0]; hif.mem_mem_read = pat[1]; hif.wb_valid = pat[2];
      hif.dmem_req = pat[2]; hif.dmem_ready = !pat[1];
      @(negedge clk);
      n_tests++;
      if ({hif.use_mem_back, hif.use_wb_back} !== {pat[0] && !pat[1], pat[2]}) begin
        n_fail++;
        $display("FAIL fwd_quals[%0d] got %b%b want %b%b", i, hif.use_mem_back, hif.use_wb_back,
                 pat[0] && !pat[1], pat[2]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mdu(input bool_dwait);
    logic [7:0] exp;
    int last;
    do_reset();
    hif.ex_mdu_start = 1'b1;
    last = bool_dwait ? MDU + 2 : MDU - 1;
    for (int i = 0; i <= last; i++) begin
      hif.dmem_req   = bool_dwait && (i >= 3) && (i <= 6);
      hif.dmem_ready = !(bool_dwait && (i >= 3) && (i <= 5));
      if (bool_dwait && i >= 3 && i <= 5) exp = C_DW;
      else exp = (i == last) ? C_RUN : C_MDU;
      @(negedge clk);
      n_tests++;
      if (ctrl_obs !== exp || hif.mdu_done !== 1'b0) begin
        n_fail++;
        $display("FAIL mdu%s_cycle%0d got %b done=%b want %b done=0", bool_dwait ? "_dw" : "",
                 i, ctrl_obs, hif.mdu_done, exp);
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (hif.mdu_done !== 1'b1) begin n_fail++; $display("FAIL mdu_done_pulse got %b want 1", hif.mdu_done); end
    n_tests++;
    if (stall_cycles !== CW'(bool_dwait ? MDU + 2 : MDU - 1)) begin
      n_fail++;
      $display("FAIL mdu_stall_cnt got %0d want %0d", stall_cycles, bool_dwait ? MDU + 2 : MDU - 1);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (hif.mdu_done !== 1'b0) begin n_fail++; $display("FAIL mdu_done_width got %b want 0", hif.mdu_done); end
  endtask

  task automatic test_redirect();
    do_reset();
    hif.ex_redirect = 1'b1;
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd9; hif.id_rt = 5'd9; hif.id_use_rt = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RED) begin n_fail++; $display("FAIL redirect_lu got %b want %b", ctrl_obs, C_RED); end
    tick();
    idle();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b1; hif.ex_redirect = 1'b1;
    @(negedge clk);
    n_tests++;
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL redirect_nostall got %0d want 0", stall_cycles); end
    n_tests++;
    if (ctrl_obs !== C_RED) begin n_fail++; $display("FAIL dmem_zero_wait got %b want %b", ctrl_obs, C_RED); end
    tick();
    hif.dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (ctrl_obs !== C_DW) begin n_fail++; $display("FAIL dwait_ignore_redir%0d got %b want %b", i, ctrl_obs, C_DW); end
      tick();
    end
    hif.dmem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RED) begin n_fail++; $display("FAIL dwait_return got %b want %b", ctrl_obs, C_RED); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    hif.ex_mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    hif.ex_mdu_start = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_obs !== C_RUN || stall_cycles !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mdu got %b cnt=%0d want %b cnt=0", ctrl_obs, stall_cycles, C_RUN);
    end
    for (int i = 0; i < MDU + 2; i++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (hif.mdu_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_mdu_done%0d got 1 want 0", i); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    n_tests++;
    if (stall_cycles !== 4'hF || ctrl_obs !== C_DW) begin
      n_fail++;
      $display("FAIL saturate got cnt=%0d ctrl=%b want cnt=15 ctrl=%b", stall_cycles, ctrl_obs, C_DW);
    end
    idle();
    tick();
  endtask

  // Reference model: EX occupancy tracked as remaining cycles of the multi-cycle op.
  task automatic test_random();
    logic       busy = 1'b0, done_q = 1'b0, done_n, dw, lu;
    int         left = 0, stalls = 0;
    logic [7:0] exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hif.id_rs = 5'($urandom_range(0, 3)); hif.id_rt = 5'($urandom_range(0, 3));
      hif.ex_rd = 5'($urandom_range(0, 3));
      hif.id_use_rs = 1'($urandom_range(0, 1)); hif.id_use_rt = 1'($urandom_range(0, 1));
      hif.ex_mem_read = 1'($urandom_range(0, 1));
      hif.ex_mdu_start = ($urandom_range(0, 11) == 0);
      hif.ex_redirect = ($urandom_range(0, 5) == 0);
      hif.mem_valid = 1'($urandom_range(0, 1)); hif.mem_mem_read = 1'($urandom_range(0, 1));
      hif.wb_valid = 1'($urandom_range(0, 1));
      hif.dmem_req = ($urandom_range(0, 3) == 0); hif.dmem_ready = 1'($urandom_range(0, 1));
      dw = hif.dmem_req && !hif.dmem_ready;
      lu = hif.ex_mem_read && hif.ex_rd != 0 &&
           ((hif.id_use_rs && hif.id_rs == hif.ex_rd) || (hif.id_use_rt && hif.id_rt == hif.ex_rd));
      done_n = 1'b0;
      if (dw) exp = C_DW;
      else if (busy) exp = (left == 1) ? C_RUN : C_MDU;
      else if (hif.ex_mdu_start) exp = C_MDU;
      else if (hif.ex_redirect) exp = C_RED;
      else if (lu) exp = C_LU;
      else exp = C_RUN;
      @(negedge clk);
      n_tests++;
      if ({ctrl_obs, hif.mdu_done, hif.use_mem_back, hif.use_wb_back, stall_cycles} !==
          {exp, done_q, hif.mem_valid && !hif.mem_mem_read, hif.wb_valid, CW'(stalls)}) begin
        n_fail++;
        $display("FAIL random_c%0d got ctrl=%b done=%b mb=%b wb=%b cnt=%0d want ctrl=%b done=%b mb=%b wb=%b cnt=%0d",
                 c, ctrl_obs, hif.mdu_done, hif.use_mem_back, hif.use_wb_back, stall_cycles,
                 exp, done_q, hif.mem_valid && !hif.mem_mem_read, hif.wb_valid, stalls);
      end
      if (!dw) begin
        if (busy) begin
          if (left == 1) begin busy = 1'b0; done_n = 1'b1; end
          else left--;
        end else if (hif.ex_mdu_start) begin
          busy = 1'b1;
          left = MDU - 1;
        end
      end
      done_q = done_n;
      if (!exp[7] && stalls < (1 << CW) - 1) stalls++;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    tick();
    test_reset();
    test_load_use();
    test_forward_quals();
    test_mdu(1'b0);
    test_mdu(1'b1);
    test_redirect();
    test_reset_mid_mdu();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
